// File: rtl/doubly_linked_list_if.sv
// Request/response bundle shared by the linked-list family: opcode handshake plus list status.
interface doubly_linked_list_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [2:0]            op;
    logic                  op_start;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  op_done;
    logic [ADDR_WIDTH-1:0] next_node_addr;
    logic [ADDR_WIDTH-1:0] pre_node_addr;
    logic [ADDR_WIDTH-1:0] length;
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  full;
    logic                  empty;
    logic                  fault;

    modport master (
        output data_in, addr_in, op, op_start,
        input  data_out, op_done, next_node_addr, pre_node_addr,
        input  length, head, tail, full, empty, fault
    );

    modport slave (
        input  data_in, addr_in, op, op_start,
        output data_out, op_done, next_node_addr, pre_node_addr,
        output length, head, tail, full, empty, fault
    );
endinterface

// File: rtl/doubly_linked_list.sv
// Doubly linked list over a fixed node pool with lowest-free-slot allocation;
// index operations walk from whichever end of the list is nearer.
module doubly_linked_list #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    parameter int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    doubly_linked_list_if.slave  bus
);
    localparam int                    IDX_W     = $clog2(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = '1;
    localparam logic [ADDR_WIDTH-1:0] NODE_CNT  = ADDR_WIDTH'(MAX_NODE);

    localparam logic [2:0] OP_READ     = 3'b000;
    localparam logic [2:0] OP_INS_ADDR = 3'b001;
    localparam logic [2:0] OP_DEL_VAL  = 3'b010;
    localparam logic [2:0] OP_DEL_ADDR = 3'b011;
    localparam logic [2:0] OP_UPDATE   = 3'b100;
    localparam logic [2:0] OP_INS_IDX  = 3'b101;
    localparam logic [2:0] OP_CLEAR    = 3'b110;
    localparam logic [2:0] OP_DEL_IDX  = 3'b111;

    typedef enum logic [2:0] {IDLE, WALK_FWD, WALK_BWD, SEARCH, EXEC, DONE} state_t;

    state_t                state;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] tgt_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  miss_q;
    logic [MAX_NODE-1:0]   valid;
    logic [ADDR_WIDTH-1:0] length_q;
    logic [ADDR_WIDTH-1:0] head_q;
    logic [ADDR_WIDTH-1:0] tail_q;

    logic [DATA_WIDTH-1:0] data_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0] next_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0] prev_mem [MAX_NODE];

    function automatic logic [IDX_W-1:0] ix(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    function automatic logic node_ok(input logic [ADDR_WIDTH-1:0] a, input logic [MAX_NODE-1:0] v);
        return (a < NODE_CNT) && v[ix(a)];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [MAX_NODE-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        r = ADDR_NULL;
        for (int i = MAX_NODE - 1; i >= 0; i--)
            if (!v[i]) r = ADDR_WIDTH'(i);
        return r;
    endfunction

    logic                  full_w;
    logic                  idx_op;
    logic                  idx_in_list;
    logic                  walk_fwd;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] bwd_cnt;

    assign full_w      = (length_q == NODE_CNT);
    assign idx_op      = (bus.op == OP_INS_IDX) || (bus.op == OP_DEL_IDX);
    assign idx_in_list = (bus.addr_in < length_q);
    assign last_idx    = length_q - ADDR_WIDTH'(1);
    assign walk_fwd    = (bus.addr_in <= (last_idx >> 1));
    assign bwd_cnt     = last_idx - bus.addr_in;

    logic [ADDR_WIDTH-1:0] free_addr;
    logic [ADDR_WIDTH-1:0] tgt_next;
    logic [ADDR_WIDTH-1:0] tgt_prev;
    logic [ADDR_WIDTH-1:0] ins_prev;
    logic                  tgt_ok;
    logic                  exec_fault;

    // A NULL insert target means append, so the new node's predecessor is the tail.
    always_comb begin
        free_addr  = lowest_free(valid);
        tgt_ok     = node_ok(tgt_q, valid);
        tgt_next   = next_mem[ix(tgt_q)];
        tgt_prev   = prev_mem[ix(tgt_q)];
        ins_prev   = (tgt_q == ADDR_NULL) ? tail_q : tgt_prev;
        exec_fault = 1'b0;
        case (op_q)
            OP_READ, OP_UPDATE, OP_DEL_ADDR: exec_fault = !tgt_ok;
            OP_INS_ADDR, OP_INS_IDX:         exec_fault = full_w || ((tgt_q != ADDR_NULL) && !tgt_ok);
            OP_DEL_VAL, OP_DEL_IDX:          exec_fault = miss_q || !tgt_ok;
            default:                         exec_fault = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            op_q               <= OP_READ;
            tgt_q              <= ADDR_NULL;
            cnt_q              <= '0;
            miss_q             <= 1'b0;
            valid              <= '0;
            length_q           <= '0;
            head_q             <= ADDR_NULL;
            tail_q             <= ADDR_NULL;
            bus.data_out       <= '0;
            bus.op_done        <= 1'b0;
            bus.fault          <= 1'b0;
            bus.next_node_addr <= ADDR_NULL;
            bus.pre_node_addr  <= ADDR_NULL;
        end else begin
            bus.op_done <= 1'b0;
            case (state)
                IDLE: if (bus.op_start) begin
                    op_q   <= bus.op;
                    tgt_q  <= bus.addr_in;
                    cnt_q  <= '0;
                    miss_q <= 1'b0;
                    state  <= EXEC;
                    if (idx_op && idx_in_list && !((bus.op == OP_INS_IDX) && full_w)) begin
                        state <= walk_fwd ? WALK_FWD : WALK_BWD;
                        tgt_q <= walk_fwd ? head_q : tail_q;
                        cnt_q <= walk_fwd ? bus.addr_in : bwd_cnt;
                    end else if (bus.op == OP_INS_IDX) begin
                        tgt_q <= ADDR_NULL;
                    end else if (bus.op == OP_DEL_IDX) begin
                        miss_q <= 1'b1;
                    end else if (bus.op == OP_DEL_VAL) begin
                        if (length_q == '0) begin
                            miss_q <= 1'b1;
                        end else begin
                            tgt_q <= head_q;
                            state <= SEARCH;
                        end
                    end
                end
                WALK_FWD: if (cnt_q == '0) state <= EXEC;
                          else begin
                              tgt_q <= next_mem[ix(tgt_q)];
                              cnt_q <= cnt_q - ADDR_WIDTH'(1);
                          end
                WALK_BWD: if (cnt_q == '0) state <= EXEC;
                          else begin
                              tgt_q <= prev_mem[ix(tgt_q)];
                              cnt_q <= cnt_q - ADDR_WIDTH'(1);
                          end
                SEARCH: if (data_mem[ix(tgt_q)] == data_q) begin
                    state <= EXEC;
                end else if (next_mem[ix(tgt_q)] == ADDR_NULL) begin
                    miss_q <= 1'b1;
                    state  <= EXEC;
                end else begin
                    tgt_q <= next_mem[ix(tgt_q)];
                end
                EXEC: begin
                    bus.op_done <= 1'b1;
                    bus.fault   <= exec_fault;
                    state       <= DONE;
                    if (!exec_fault) begin
                        case (op_q)
                            OP_READ, OP_UPDATE: begin
                                bus.data_out       <= (op_q == OP_UPDATE) ? data_q : data_mem[ix(tgt_q)];
                                bus.next_node_addr <= tgt_next;
                                bus.pre_node_addr  <= tgt_prev;
                            end
                            OP_INS_ADDR, OP_INS_IDX: begin
                                bus.data_out          <= data_q;
                                bus.next_node_addr    <= tgt_q;
                                bus.pre_node_addr     <= ins_prev;
                                valid[ix(free_addr)]  <= 1'b1;
                                length_q              <= length_q + ADDR_WIDTH'(1);
                                if (ins_prev == ADDR_NULL) head_q <= free_addr;
                                if (tgt_q == ADDR_NULL)    tail_q <= free_addr;
                            end
                            OP_CLEAR: begin
                                valid    <= '0;
                                length_q <= '0;
                                head_q   <= ADDR_NULL;
                                tail_q   <= ADDR_NULL;
                            end
                            default: begin
                                bus.data_out       <= data_mem[ix(tgt_q)];
                                bus.next_node_addr <= tgt_next;
                                bus.pre_node_addr  <= tgt_prev;
                                valid[ix(tgt_q)]   <= 1'b0;
                                length_q           <= length_q - ADDR_WIDTH'(1);
                                if (tgt_prev == ADDR_NULL) head_q <= tgt_next;
                                if (tgt_next == ADDR_NULL) tail_q <= tgt_prev;
                            end
                        endcase
                    end
                    // Back-to-back reads stay in EXEC so op_done holds high.
                    if ((op_q == OP_READ) && bus.op_start && (bus.op == OP_READ)) begin
                        tgt_q <= bus.addr_in;
                        state <= EXEC;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Node storage carries no reset; the valid bits alone define pool occupancy.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.op_start) data_q <= bus.data_in;
        if ((state == EXEC) && !exec_fault) begin
            case (op_q)
                OP_UPDATE: data_mem[ix(tgt_q)] <= data_q;
                OP_INS_ADDR, OP_INS_IDX: begin
                    data_mem[ix(free_addr)] <= data_q;
                    next_mem[ix(free_addr)] <= tgt_q;
                    prev_mem[ix(free_addr)] <= ins_prev;
                    if (ins_prev != ADDR_NULL) next_mem[ix(ins_prev)] <= free_addr;
                    if (tgt_q != ADDR_NULL)    prev_mem[ix(tgt_q)]    <= free_addr;
                end
                OP_DEL_VAL, OP_DEL_ADDR, OP_DEL_IDX: begin
                    if (tgt_prev != ADDR_NULL) next_mem[ix(tgt_prev)] <= tgt_next;
                    if (tgt_next != ADDR_NULL) prev_mem[ix(tgt_next)] <= tgt_prev;
                end
                default: ;
            endcase
        end
    end

    assign bus.length = length_q;
    assign bus.head   = head_q;
    assign bus.tail   = tail_q;
    assign bus.full   = full_w;
    assign bus.empty  = (length_q == '0);
endmodule

// File: tb/tb_doubly_linked_list.sv
// Directed bench for doubly_linked_list: hand-computed list contents, pointers and op latencies.
module tb_doubly_linked_list;
    localparam int DW = 8;
    localparam int MN = 8;
    localparam int AW = 4;
    localparam logic [AW-1:0] NUL = 4'hF;
    localparam logic [2:0] RD = 3'd0, INS_A = 3'd1, DEL_V = 3'd2, DEL_A = 3'd3;
    localparam logic [2:0] UPD = 3'd4, INS_I = 3'd5, CLR = 3'd6, DEL_I = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;
    logic [AW-1:0] a;
    logic          seen_done;
    logic [DW-1:0] exp_fwd [3];
    logic [DW-1:0] exp_rev [3];

    doubly_linked_list_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    doubly_linked_list #(.DATA_WIDTH(DW), .MAX_NODE(MN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                          output int cyc);
        @(negedge clk);
        bus.op = o; bus.addr_in = ad; bus.data_in = d; bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        cyc = 0;
        while (bus.op_done !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("op_done_seen", 32'(bus.op_done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_fwd = '{8'd0, 8'd3, 8'd5};
        exp_rev = '{8'd5, 8'd3, 8'd0};
        bus.op = RD; bus.addr_in = '0; bus.data_in = '0; bus.op_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_op_done", 32'(bus.op_done), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_next", 32'(bus.next_node_addr), 32'(NUL));
        check("rst_pre", 32'(bus.pre_node_addr), 32'(NUL));
        check("rst_head", 32'(bus.head), 32'(NUL));
        check("rst_tail", 32'(bus.tail), 32'(NUL));
        check("rst_length", 32'(bus.length), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        rst = 1'b1;

        // 1: build [0,3,5] by index inserts
        run_op(INS_I, 4'd0, 8'd3, lat);
        check("t1_ins0_lat", 32'(lat), 1);
        run_op(INS_I, 4'd0, 8'd0, lat);
        check("t1_ins1_lat", 32'(lat), 2);
        check("t1_ins1_next", 32'(bus.next_node_addr), 0);
        check("t1_ins1_pre", 32'(bus.pre_node_addr), 32'(NUL));
        run_op(INS_I, 4'd5, 8'd5, lat);
        check("t1_ins2_lat", 32'(lat), 1);
        check("t1_ins2_next", 32'(bus.next_node_addr), 32'(NUL));
        check("t1_head", 32'(bus.head), 1);
        check("t1_tail", 32'(bus.tail), 2);
        check("t1_length", 32'(bus.length), 3);
        a = bus.head;
        for (int i = 0; i < 3; i++) begin
            run_op(RD, a, 8'd0, lat);
            check("t1_fwd_data", 32'(bus.data_out), 32'(exp_fwd[i]));
            a = bus.next_node_addr;
        end
        check("t1_fwd_end", 32'(a), 32'(NUL));
        a = bus.tail;
        for (int i = 0; i < 3; i++) begin
            run_op(RD, a, 8'd0, lat);
            check("t1_rev_data", 32'(bus.data_out), 32'(exp_rev[i]));
            a = bus.pre_node_addr;
        end
        check("t1_rev_end", 32'(a), 32'(NUL));

        // pipelined reads with op_start held
        @(negedge clk); bus.op = RD; bus.addr_in = 4'd1; bus.op_start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.addr_in = 4'd0;
        @(posedge clk); #1;
        check("pr_done0", 32'(bus.op_done), 1);
        check("pr_data0", 32'(bus.data_out), 0);
        check("pr_next0", 32'(bus.next_node_addr), 0);
        @(negedge clk); bus.addr_in = 4'd2;
        @(posedge clk); #1;
        check("pr_done1", 32'(bus.op_done), 1);
        check("pr_data1", 32'(bus.data_out), 3);
        check("pr_pre1", 32'(bus.pre_node_addr), 1);
        @(negedge clk); bus.op_start = 1'b0;
        @(posedge clk); #1;
        check("pr_data2", 32'(bus.data_out), 5);
        check("pr_next2", 32'(bus.next_node_addr), 32'(NUL));
        @(posedge clk); #1;
        check("pr_done_end", 32'(bus.op_done), 0);

        // 2: fill to 8, insert when full, clear
        for (int i = 0; i < 5; i++) run_op(INS_A, NUL, 8'(8'h10 + i), lat);
        check("t2_full", 32'(bus.full), 1);
        check("t2_tail", 32'(bus.tail), 7);
        run_op(INS_I, 4'd0, 8'd9, lat);
        check("t2_ovf_lat", 32'(lat), 1);
        check("t2_ovf_fault", 32'(bus.fault), 1);
        check("t2_ovf_length", 32'(bus.length), 8);
        check("t2_ovf_head", 32'(bus.head), 1);
        run_op(RD, 4'd1, 8'd0, lat);
        check("t2_head_data", 32'(bus.data_out), 0);
        check("t2_rd_fault", 32'(bus.fault), 0);
        run_op(CLR, 4'd0, 8'd0, lat);
        check("t2_clr_lat", 32'(lat), 1);
        check("t2_clr_empty", 32'(bus.empty), 1);
        check("t2_clr_head", 32'(bus.head), 32'(NUL));
        check("t2_clr_tail", 32'(bus.tail), 32'(NUL));
        check("t2_clr_fault", 32'(bus.fault), 0);
        run_op(RD, 4'd0, 8'd0, lat);
        check("t2_rd_cleared", 32'(bus.fault), 1);

        // 3: [7,3,4,3], delete by value
        run_op(INS_A, NUL, 8'd7, lat);
        run_op(INS_A, NUL, 8'd3, lat);
        run_op(INS_A, NUL, 8'd4, lat);
        run_op(INS_A, NUL, 8'd3, lat);
        run_op(DEL_V, 4'd0, 8'd3, lat);
        check("t3_dv_lat", 32'(lat), 3);
        check("t3_dv_fault", 32'(bus.fault), 0);
        check("t3_dv_next", 32'(bus.next_node_addr), 2);
        check("t3_dv_pre", 32'(bus.pre_node_addr), 0);
        check("t3_dv_length", 32'(bus.length), 3);
        run_op(DEL_V, 4'd0, 8'd2, lat);
        check("t3_nf_lat", 32'(lat), 4);
        check("t3_nf_fault", 32'(bus.fault), 1);
        check("t3_nf_length", 32'(bus.length), 3);
        check("t3_nf_tail", 32'(bus.tail), 3);
        run_op(RD, 4'd0, 8'd0, lat);
        check("t3_link_0_2", 32'(bus.next_node_addr), 2);

        // 4: index deletes on an 8-node list
        run_op(CLR, 4'd0, 8'd0, lat);
        for (int i = 0; i < 8; i++) run_op(INS_A, NUL, 8'(8'h20 + i), lat);
        run_op(DEL_I, 4'd6, 8'd0, lat);
        check("t4_d6_lat", 32'(lat), 3);
        check("t4_d6_data", 32'(bus.data_out), 32'h26);
        check("t4_d6_next", 32'(bus.next_node_addr), 7);
        check("t4_d6_pre", 32'(bus.pre_node_addr), 5);
        run_op(DEL_I, 4'd1, 8'd0, lat);
        check("t4_d1_lat", 32'(lat), 3);
        check("t4_d1_data", 32'(bus.data_out), 32'h21);
        check("t4_d1_pre", 32'(bus.pre_node_addr), 0);
        run_op(DEL_I, 4'd8, 8'd0, lat);
        check("t4_d8_lat", 32'(lat), 1);
        check("t4_d8_fault", 32'(bus.fault), 1);
        check("t4_d8_length", 32'(bus.length), 6);
        run_op(INS_I, 4'd3, 8'h55, lat);
        check("t4_i3_lat", 32'(lat), 4);
        check("t4_i3_next", 32'(bus.next_node_addr), 4);
        check("t4_i3_pre", 32'(bus.pre_node_addr), 3);
        run_op(RD, 4'd1, 8'd0, lat);
        check("t4_i3_slot", 32'(bus.data_out), 32'h55);

        // 5: address ops and slot reuse
        run_op(CLR, 4'd0, 8'd0, lat);
        for (int i = 0; i < 3; i++) run_op(INS_A, NUL, 8'(8'hA0 + i), lat);
        run_op(DEL_A, 4'd1, 8'd0, lat);
        check("t5_da_lat", 32'(lat), 1);
        check("t5_da_data", 32'(bus.data_out), 32'hA1);
        check("t5_da_next", 32'(bus.next_node_addr), 2);
        check("t5_da_length", 32'(bus.length), 2);
        run_op(INS_A, NUL, 8'hB0, lat);
        check("t5_reuse_tail", 32'(bus.tail), 1);
        check("t5_reuse_pre", 32'(bus.pre_node_addr), 2);
        run_op(UPD, 4'd1, 8'hAA, lat);
        check("t5_upd_lat", 32'(lat), 1);
        run_op(RD, 4'd1, 8'd0, lat);
        check("t5_rd_data", 32'(bus.data_out), 32'hAA);
        check("t5_rd_next", 32'(bus.next_node_addr), 32'(NUL));
        check("t5_rd_pre", 32'(bus.pre_node_addr), 2);
        run_op(RD, 4'd5, 8'd0, lat);
        check("t5_free_fault", 32'(bus.fault), 1);
        check("t5_free_lat", 32'(lat), 1);
        run_op(DEL_A, 4'd9, 8'd0, lat);
        check("t5_bad_addr", 32'(bus.fault), 1);
        run_op(INS_A, 4'd0, 8'hC0, lat);
        check("t5_ih_head", 32'(bus.head), 3);
        check("t5_ih_pre", 32'(bus.pre_node_addr), 32'(NUL));
        check("t5_ih_next", 32'(bus.next_node_addr), 0);

        // 6: reset during an index walk
        @(negedge clk); bus.op = DEL_I; bus.addr_in = 4'd1; bus.op_start = 1'b1;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_length", 32'(bus.length), 0);
        check("t6_head", 32'(bus.head), 32'(NUL));
        check("t6_empty", 32'(bus.empty), 1);
        check("t6_op_done", 32'(bus.op_done), 0);
        check("t6_data_out", 32'(bus.data_out), 0);
        check("t6_next", 32'(bus.next_node_addr), 32'(NUL));
        @(negedge clk); rst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.op_done) seen_done = 1'b1;
        end
        check("t6_no_done", 32'(seen_done), 0);
        run_op(INS_A, NUL, 8'h77, lat);
        check("t6_ins_head", 32'(bus.head), 0);
        check("t6_ins_tail", 32'(bus.tail), 0);
        check("t6_ins_length", 32'(bus.length), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/doubly_linked_list.md
Name: doubly_linked_list

Overview:
Parametrised successor to the singly linked list. Node pool of MAX_NODE entries, each with data, next pointer and prev pointer, with a free-slot allocator. Supports forward and reverse traversal, in-place data update and single-op clear. Index operations walk from whichever end of the list is nearer. Drop-in replacement in the list/queue family: same op/op_start/op_done handshake, plus the pre_node_addr output.

Parameters:
DATA_WIDTH, 8, width of node data
MAX_NODE, 8, node pool depth (>=2)
ADDR_WIDTH, $clog2(MAX_NODE+1), node address width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
data_in  input  DATA_WIDTH  write data / search value
addr_in  input  ADDR_WIDTH  node address or list index, depending on op
op  input  3  opcode
op_start  input  1  request; sampled in IDLE
data_out  output  DATA_WIDTH  data of the node accessed by the last op
op_done  output  1  one-cycle completion pulse per op
next_node_addr  output  ADDR_WIDTH  next pointer of the accessed node
pre_node_addr  output  ADDR_WIDTH  prev pointer of the accessed node
length  output  ADDR_WIDTH  node count
head  output  ADDR_WIDTH  head address
tail  output  ADDR_WIDTH  tail address
full  output  1  length==MAX_NODE
empty  output  1  length==0
fault  output  1  last op was illegal; valid with op_done

Behaviour:
- Addressing:
  - ADDR_NULL = all ones; valid addresses are 0..MAX_NODE-1.
  - Insert allocates the lowest-numbered free slot (priority encoder).
- Opcodes:
  - 000 Read_Addr
  - 001 Insert_Before_Addr (addr_in==ADDR_NULL appends at tail)
  - 010 Delete_Value (first match from head)
  - 011 Delete_At_Addr
  - 100 Update_At_Addr (overwrites data only)
  - 101 Insert_At_Index (index >= length appends at tail)
  - 110 Clear
  - 111 Delete_At_Index
- Reset (asynchronous, rst low): state IDLE; data_out=0, op_done=0, fault=0; next_node_addr=pre_node_addr=head=tail=ADDR_NULL; length=0; empty=1; full=0; all valid bits cleared.
- Reset mid-operation aborts the op with no op_done. Reset has priority over all ops.
- FSM states:
  - IDLE: op_start=1 latches op, addr_in and data_in.
  - WALK_FWD / WALK_BWD: one node per cycle.
  - SEARCH: compare one node per cycle, from head.
  - EXEC: pointer/valid update.
  - DONE: op_done=1 for one cycle, then IDLE.
- Latency, cycles from the op_start sampling edge to op_done high:
  - Read, Update, Clear, address-based Insert/Delete, and all faulting ops except Delete_Value: 1.
  - Read is pipelined. With op_start held, a read is accepted every cycle; op_done stays high, and data_out, next_node_addr and pre_node_addr track each addr_in.
  - Index ops: min(idx, length-1-idx)+2. Walk direction is forward when idx <= (length-1)/2, else backward from tail.
  - Delete_Value: k+2 when matched at position k. Not found: length+1, with fault.
- For non-read ops, op_start still high after op_done starts a new op next cycle using current inputs.
- Output updates:
  - data_out, next_node_addr, pre_node_addr reflect the accessed node.
  - For inserts they reflect the new node. For deletes they reflect the removed node's pointers as they were before removal.
  - length, head, tail, full, empty update on the op_done edge.
- Fault cases (list unchanged, fault=1 with op_done; fault=0 otherwise):
  - insert when full;
  - read/update/delete at an invalid or free address;
  - Delete_At_Index with idx >= length;
  - Delete_Value not found;
  - any delete on an empty list.
- Clear never faults. It invalidates all nodes and sets head=tail=ADDR_NULL in 1 cycle.
- Boundary rules:
  - Inserting at head sets the new node's prev=ADDR_NULL. Appending sets next=ADDR_NULL.
  - Deleting the last node returns head=tail=ADDR_NULL and empty=1.
  - op_start is ignored outside IDLE.

Test Plan:
1. Reset, then Insert_At_Index(0,3), (0,0), (5,5) -> list [0,3,5]. Slots 1,0,2; head=1, tail=2, length=3. Forward reads chained via next_node_addr return 0,3,5. Reverse reads chained via pre_node_addr from tail return 5,3,0.
2. Fill to 8 nodes, then Insert_At_Index(0,9) -> fault=1, full=1, length=8, contents unchanged. A following Clear -> empty=1, head=tail=ADDR_NULL, fault=0.
3. List [7,3,4,3]: Delete_Value(3) -> index 1 removed, op_done at cycle 3, list [7,4,3]. Delete_Value(2) -> fault=1 at cycle 4, list unchanged.
4. 8-node list: Delete_At_Index(6) -> op_done at cycle 3 (backward walk). Delete_At_Index(1) -> cycle 3 (forward walk). Delete_At_Index(8) -> fault=1, cycle 1.
5. Delete_At_Addr(1) on a 3-node list, then insert -> the new node occupies slot 1. Update_At_Addr(1,0xAA) then Read_Addr(1) -> data_out=0xAA, pointers unchanged. Read_Addr(5) with slot 5 free -> fault=1.
6. Assert rst low during an Index walk -> all outputs at reset values immediately, no op_done after release. A subsequent insert gets address 0.
